decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL: instr_valid / instr_ready  in / out  1 / 1  fetch handshake; transfer when both are high.
REQ-004 SHALL: instr, instr_pc  in  32, 32  RV32I instruction word and its PC.
REQ-005 SHALL: rs1_addr, rs2_addr  out  5, 5  register-file read addresses, equal to instr[19:15] and instr[24:20].
REQ-006 SHALL: read_rs1, read_rs2  out  1, 1  register-file read strobes; the register file captures rs1/rs2 on the edge a strobe is high and holds them otherwise.
REQ-007 SHALL: iss_valid / iss_ready  out / in  1 / 1  issue handshake to execute.
REQ-008 SHALL: iss_op  out  4  op class (ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL); iss_funct  out  4  {funct7[5], funct3}.
REQ-009 SHALL: iss_rd  out  5; iss_rd_write  out  1; iss_imm  out  32 sign-extended; iss_pc  out  32.
REQ-010 SHALL: wb_valid, wb_rd  in  1, 5  writeback completion; clears the scoreboard bit of wb_rd.
REQ-011 SHALL: stall_cnt  out  16  saturating count of cycles with instr_valid=1 and instr_ready=0.

Function
REQ-012 SHALL decode combinationally from instr; uses_rs1/uses_rs2/rd_write per RV32I opcode; unknown opcode -> ILLEGAL, no reads, rd_write=0.
REQ-013 SHALL force rd_write=0 when rd=0 and treat x0 as never busy.
REQ-014 SHALL keep a 32-bit scoreboard; bit n is set on acceptance of an instruction with rd_write=1 and rd=n.
REQ-015 SHALL clear scoreboard bit wb_rd when wb_valid=1; same-cycle clear does not unblock the current decode (no bypass); the waiting instruction is accepted on the following cycle.
REQ-016 SHALL raise hazard when an used source or the destination (WAW) has its scoreboard bit set.
REQ-017 SHALL drive instr_ready = !hazard && (!iss_valid || iss_ready).
REQ-018 SHALL drive read_rs1 = instr_valid && instr_ready && uses_rs1, and likewise for read_rs2, so operands arrive in the cycle iss_valid rises.
REQ-019 SHALL load the issue register one cycle after acceptance (latency 1); iss_valid and all iss_* fields hold stable while iss_valid && !iss_ready.
REQ-020 SHALL clear iss_valid when iss_ready=1 and no new instruction is accepted; back-to-back acceptance gives one issue per cycle.
REQ-021 SHALL issue ILLEGAL ops normally (no scoreboard set) so execute can trap.
REQ-022 SHALL saturate stall_cnt at 16'hFFFF.

Reset
REQ-023 SHALL on reset: iss_valid=0, scoreboard=0, stall_cnt=0, iss_op=ILLEGAL, iss_rd=0, iss_rd_write=0, iss_imm=0, iss_pc=0, iss_funct=0.
REQ-024 SHALL discard the issue-register instruction when reset asserts mid-operation; instr_ready follows REQ-017 from the cleared state.

Structure
REQ-025 SHALL take opcode constants, the op-class enum and the iss_funct encoding from shared package rv_pkg.
REQ-026 SHALL place immediate generation (I/S/B/U/J formats) in sub-module imm_gen (32-bit instr in, 32-bit imm out, combinational).

Verification
REQ-027 SHALL cover: addi x1,x0,-3 (0xFFD00093), iss_ready=1 -> next cycle iss_op=ALU_I, iss_imm=0xFFFFFFFD, iss_rd=1, scoreboard[1]=1, read_rs1=1 at acceptance.
REQ-028 SHALL cover: add x3,x1,x2 while x1 busy -> instr_ready=0 and stall_cnt increments; wb_valid,wb_rd=1 -> accepted the following cycle.
REQ-029 SHALL cover: iss_ready=0 for 3 cycles with iss_valid=1 -> all iss_* stable, instr_ready=0, read strobes low.
REQ-030 SHALL cover: addi x0,x0,5 -> iss_rd_write=0, scoreboard unchanged; opcode 0x7F -> ILLEGAL, read strobes 0.
REQ-031 SHALL cover: reset asserted asynchronously mid-stall with x5 busy -> iss_valid=0 and scoreboard=0 before the next edge; a dependent instruction is then accepted at once.
REQ-032 SHALL cover: stall_cnt preloaded near saturation by a 65540-cycle stall -> holds 0xFFFF.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants, op classes and issue bundle
// Imported by the decode/issue stage and anything that consumes it.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_R   = 4'd0,
        ALU_I   = 4'd1,
        LOAD    = 4'd2,
        STORE   = 4'd3,
        BRANCH  = 4'd4,
        JAL     = 4'd5,
        JALR    = 4'd6,
        LUI     = 4'd7,
        AUIPC   = 4'd8,
        SYSTEM  = 4'd9,
        ILLEGAL = 4'd10
    } op_e;

    typedef struct packed {
        op_e  op;
        logic uses_rs1;
        logic uses_rs2;
        logic rd_write;
    } dec_t;

    typedef struct packed {
        op_e         op;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        rd_write;
        logic [31:0] imm;
        logic [31:0] pc;
    } iss_t;

    localparam iss_t ISS_RESET = '{
        op:       ILLEGAL,
        funct:    4'd0,
        rd:       5'd0,
        rd_write: 1'b0,
        imm:      32'd0,
        pc:       32'd0
    };

    // execute sees {funct7[5], funct3} for every op class
    function automatic logic [3:0] funct_of(input logic [31:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch handshake, regfile strobes, issue bundle, writeback
// slave = decode/issue stage, master = fetch/execute/regfile environment.
interface decode_issue_if;
    import rv_pkg::*;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        read_rs1;
    logic        read_rs2;

    logic        iss_valid;
    logic        iss_ready;
    op_e         iss_op;
    logic [3:0]  iss_funct;
    logic [4:0]  iss_rd;
    logic        iss_rd_write;
    logic [31:0] iss_imm;
    logic [31:0] iss_pc;

    logic        wb_valid;
    logic [4:0]  wb_rd;

    logic [15:0] stall_cnt;

    modport slave (
        input  instr_valid, instr, instr_pc,
        input  iss_ready, wb_valid, wb_rd,
        output instr_ready, rs1_addr, rs2_addr,
        output read_rs1, read_rs2,
        output iss_valid, iss_op, iss_funct, iss_rd,
        output iss_rd_write, iss_imm, iss_pc,
        output stall_cnt
    );

    modport master (
        output instr_valid, instr, instr_pc,
        output iss_ready, wb_valid, wb_rd,
        input  instr_ready, rs1_addr, rs2_addr,
        input  read_rs1, read_rs2,
        input  iss_valid, iss_op, iss_funct, iss_rd,
        input  iss_rd_write, iss_imm, iss_pc,
        input  stall_cnt
    );

endinterface

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate extraction (I/S/B/U/J), sign-extended to 32 bits
// Opcodes without an immediate (R-type, unknown) yield zero.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    // pick the format that belongs to the opcode
    always_comb begin
        imm = 32'd0;
        unique case (instr[6:0])
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR,
            OPC_SYSTEM: imm = imm_i;
            OPC_STORE:  imm = imm_s;
            OPC_BRANCH: imm = imm_b;
            OPC_LUI,
            OPC_AUIPC:  imm = imm_u;
            OPC_JAL:    imm = imm_j;
            default:    imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode, scoreboard hazard check, one-entry issue register
// Operands are read on the accept edge so they line up with iss_valid.
module decode_issue
    import rv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    decode_issue_if.slave bus
);

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    dec_t        dec;
    logic        rd_write;
    logic [31:0] imm;

    logic [31:0] scoreboard;
    logic [31:0] sb_next;
    logic        hazard;
    logic        instr_ready;
    logic        accept;

    logic        iss_valid;
    iss_t        iss_q;
    logic [15:0] stall_q;

    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];
    assign rd  = bus.instr[11:7];
    assign f3  = bus.instr[14:12];

    imm_gen u_imm_gen (
        .instr (bus.instr),
        .imm   (imm)
    );

    // op class and register usage from the opcode
    always_comb begin
        dec.op       = ILLEGAL;
        dec.uses_rs1 = 1'b0;
        dec.uses_rs2 = 1'b0;
        dec.rd_write = 1'b0;
        unique case (bus.instr[6:0])
            OPC_OP: begin
                dec.op       = ALU_R;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.rd_write = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.op       = ALU_I;
                dec.uses_rs1 = 1'b1;
                dec.rd_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.op       = LOAD;
                dec.uses_rs1 = 1'b1;
                dec.rd_write = 1'b1;
            end
            OPC_STORE: begin
                dec.op       = STORE;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.op       = BRANCH;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                dec.op       = JAL;
                dec.rd_write = 1'b1;
            end
            OPC_JALR: begin
                dec.op       = JALR;
                dec.uses_rs1 = 1'b1;
                dec.rd_write = 1'b1;
            end
            OPC_LUI: begin
                dec.op       = LUI;
                dec.rd_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op       = AUIPC;
                dec.rd_write = 1'b1;
            end
            OPC_SYSTEM: begin
                // CSR ops write rd; the register forms also read rs1
                dec.op       = SYSTEM;
                dec.uses_rs1 = !f3[2] && (f3 != 3'd0);
                dec.rd_write = (f3 != 3'd0);
            end
            default: begin
                dec.op       = ILLEGAL;
                dec.uses_rs1 = 1'b0;
                dec.uses_rs2 = 1'b0;
                dec.rd_write = 1'b0;
            end
        endcase
    end

    assign rd_write = dec.rd_write && (rd != 5'd0);

    // bit 0 is never set, so x0 can never look busy
    assign hazard = (dec.uses_rs1 && scoreboard[rs1])
                 || (dec.uses_rs2 && scoreboard[rs2])
                 || (rd_write && scoreboard[rd]);

    assign instr_ready = !hazard && (!iss_valid || bus.iss_ready);
    assign accept      = bus.instr_valid && instr_ready;

    // writeback clears, acceptance sets; neither feeds this cycle's hazard
    always_comb begin
        sb_next = scoreboard;
        if (bus.wb_valid) begin
            sb_next[bus.wb_rd] = 1'b0;
        end
        if (accept && rd_write) begin
            sb_next[rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scoreboard <= 32'd0;
        end else begin
            scoreboard <= sb_next;
        end
    end

    // issue register: load on accept, drain when execute takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid <= 1'b0;
            iss_q     <= ISS_RESET;
        end else if (accept) begin
            iss_valid      <= 1'b1;
            iss_q.op       <= dec.op;
            iss_q.funct    <= funct_of(bus.instr);
            iss_q.rd       <= rd;
            iss_q.rd_write <= rd_write;
            iss_q.imm      <= imm;
            iss_q.pc       <= bus.instr_pc;
        end else if (bus.iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

    // saturating count of cycles fetch waits on us
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (bus.instr_valid && !instr_ready
                     && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.instr_ready  = instr_ready;
    assign bus.rs1_addr     = rs1;
    assign bus.rs2_addr     = rs2;
    assign bus.read_rs1     = accept && dec.uses_rs1;
    assign bus.read_rs2     = accept && dec.uses_rs2;
    assign bus.iss_valid    = iss_valid;
    assign bus.iss_op       = iss_q.op;
    assign bus.iss_funct    = iss_q.funct;
    assign bus.iss_rd       = iss_q.rd;
    assign bus.iss_rd_write = iss_q.rd_write;
    assign bus.iss_imm      = iss_q.imm;
    assign bus.iss_pc       = iss_q.pc;
    assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed + random stimulus against a behavioural model
// Model tracks busy registers, the pending issue slot and the stall counter.
module tb_decode_issue;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    decode_issue_if bus ();

    decode_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          busy [32];
    bit          m_iss_valid;
    op_e         m_op;
    logic [3:0]  m_funct;
    logic [4:0]  m_rd;
    bit          m_rdw;
    logic [31:0] m_imm;
    logic [31:0] m_pc;
    int          m_stall;
    bit          acc_last;

    logic [6:0] opcs [0:9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                               7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] w,
                                       output op_e cls, output bit u1,
                                       output bit u2, output bit rw,
                                       output logic [31:0] imm);
        int v;
        logic [2:0] f3;
        f3  = w[14:12];
        u1  = 0;
        u2  = 0;
        rw  = 0;
        imm = 0;
        v   = 0;
        cls = ILLEGAL;
        case (w[6:0])
            7'h33: begin cls = ALU_R; u1 = 1; u2 = 1; rw = 1; end
            7'h13: begin cls = ALU_I; u1 = 1; rw = 1;
                         v = $signed(w[31:20]); imm = v; end
            7'h03: begin cls = LOAD; u1 = 1; rw = 1;
                         v = $signed(w[31:20]); imm = v; end
            7'h23: begin cls = STORE; u1 = 1; u2 = 1;
                         v = $signed({w[31:25], w[11:7]}); imm = v; end
            7'h63: begin cls = BRANCH; u1 = 1; u2 = 1;
                         v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
                         imm = v; end
            7'h6F: begin cls = JAL; rw = 1;
                         v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
                         imm = v; end
            7'h67: begin cls = JALR; u1 = 1; rw = 1;
                         v = $signed(w[31:20]); imm = v; end
            7'h37: begin cls = LUI; rw = 1; imm = w & 32'hFFFFF000; end
            7'h17: begin cls = AUIPC; rw = 1; imm = w & 32'hFFFFF000; end
            7'h73: begin cls = SYSTEM;
                         u1 = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
                         rw = (f3 != 3'd0);
                         v = $signed(w[31:20]); imm = v; end
            default: cls = ILLEGAL;
        endcase
        if (w[11:7] == 5'd0) rw = 0;
    endfunction

    function automatic bit ref_ready(input logic [31:0] w, input bit ird);
        op_e c;
        bit u1, u2, rw, hz;
        logic [31:0] im;
        ref_decode(w, c, u1, u2, rw, im);
        hz = (u1 && busy[w[19:15]]) || (u2 && busy[w[24:20]])
          || (rw && busy[w[11:7]]);
        return !hz && (!m_iss_valid || ird);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) busy[i] = 0;
        m_iss_valid = 0;
        m_op        = ILLEGAL;
        m_funct     = 0;
        m_rd        = 0;
        m_rdw       = 0;
        m_imm       = 0;
        m_pc        = 0;
        m_stall     = 0;
        acc_last    = 0;
    endtask

    task automatic drive(input bit v, input logic [31:0] w,
                         input logic [31:0] pc, input bit ir,
                         input bit wv, input logic [4:0] wr);
        bus.instr_valid = v;
        bus.instr       = w;
        bus.instr_pc    = pc;
        bus.iss_ready   = ir;
        bus.wb_valid    = wv;
        bus.wb_rd       = wr;
    endtask

    task automatic check_all();
        op_e c;
        bit u1, u2, rw, er;
        logic [31:0] im;
        ref_decode(bus.instr, c, u1, u2, rw, im);
        er = ref_ready(bus.instr, bus.iss_ready);
        check("instr_ready", bus.instr_ready, er);
        check("read_rs1", bus.read_rs1, bus.instr_valid && er && u1);
        check("read_rs2", bus.read_rs2, bus.instr_valid && er && u2);
        check("rs1_addr", bus.rs1_addr, bus.instr[19:15]);
        check("rs2_addr", bus.rs2_addr, bus.instr[24:20]);
        check("iss_valid", bus.iss_valid, m_iss_valid);
        check("iss_op", bus.iss_op, m_op);
        check("iss_funct", bus.iss_funct, m_funct);
        check("iss_rd", bus.iss_rd, m_rd);
        check("iss_rd_write", bus.iss_rd_write, m_rdw);
        check("iss_imm", bus.iss_imm, m_imm);
        check("iss_pc", bus.iss_pc, m_pc);
        check("stall_cnt", bus.stall_cnt, m_stall);
    endtask

    task automatic tick();
        op_e c;
        bit u1, u2, rw, er, acc;
        logic [31:0] im;
        ref_decode(bus.instr, c, u1, u2, rw, im);
        er  = ref_ready(bus.instr, bus.iss_ready);
        acc = bus.instr_valid && er;
        @(posedge clk);
        if (bus.instr_valid && !er && m_stall < 65535) m_stall++;
        if (bus.wb_valid) busy[bus.wb_rd] = 0;
        if (acc) begin
            if (rw) busy[bus.instr[11:7]] = 1;
            m_iss_valid = 1;
            m_op        = c;
            m_funct     = {bus.instr[30], bus.instr[14:12]};
            m_rd        = bus.instr[11:7];
            m_rdw       = rw;
            m_imm       = im;
            m_pc        = bus.instr_pc;
        end else if (bus.iss_ready) begin
            m_iss_valid = 0;
        end
        acc_last = acc;
        @(negedge clk);
    endtask

    task automatic cycle();
        #1;
        check_all();
        tick();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] pc;
        bit v;

        reset = 1'b1;
        drive(0, 32'd0, 32'd0, 1, 0, 5'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_iss_valid", bus.iss_valid, 0);
        check("rst_iss_op", bus.iss_op, ILLEGAL);
        check("rst_iss_imm", bus.iss_imm, 0);
        check("rst_stall", bus.stall_cnt, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        cycle();

        // addi x1,x0,-3
        drive(1, 32'hFFD00093, 32'h100, 1, 0, 5'd0);
        #1;
        check("addi_read_rs1", bus.read_rs1, 1);
        check("addi_ready", bus.instr_ready, 1);
        cycle();
        #1;
        check("addi_iss_valid", bus.iss_valid, 1);
        check("addi_iss_op", bus.iss_op, ALU_I);
        check("addi_iss_imm", bus.iss_imm, 32'hFFFFFFFD);
        check("addi_iss_rd", bus.iss_rd, 1);
        check("addi_rd_write", bus.iss_rd_write, 1);

        // add x3,x1,x2 while x1 busy
        drive(1, 32'h002081B3, 32'h104, 1, 0, 5'd0);
        #1 check("raw_stall_ready", bus.instr_ready, 0);
        cycle();
        cycle();
        #1 check("raw_stall_cnt", bus.stall_cnt, 2);
        drive(1, 32'h002081B3, 32'h104, 1, 1, 5'd1);
        #1 check("wb_no_bypass", bus.instr_ready, 0);
        cycle();
        drive(1, 32'h002081B3, 32'h104, 1, 0, 5'd0);
        #1 check("wb_next_ready", bus.instr_ready, 1);
        cycle();

        // execute back-pressure for 3 cycles
        drive(1, 32'h00700213, 32'h108, 0, 0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", bus.instr_ready, 0);
            check("bp_read_rs1", bus.read_rs1, 0);
            check("bp_read_rs2", bus.read_rs2, 0);
            check("bp_iss_valid", bus.iss_valid, 1);
            check("bp_iss_op", bus.iss_op, ALU_R);
            check("bp_iss_rd", bus.iss_rd, 3);
            check("bp_iss_pc", bus.iss_pc, 32'h104);
            cycle();
        end
        drive(1, 32'h00700213, 32'h108, 1, 0, 5'd0);
        cycle();

        // addi x0,x0,5 then an unknown opcode
        drive(1, 32'h00500013, 32'h10C, 1, 0, 5'd0);
        cycle();
        #1 check("x0_rd_write", bus.iss_rd_write, 0);
        drive(1, 32'h0020807F, 32'h110, 1, 0, 5'd0);
        #1;
        check("ill_read_rs1", bus.read_rs1, 0);
        check("ill_read_rs2", bus.read_rs2, 0);
        check("ill_ready", bus.instr_ready, 1);
        cycle();
        #1 check("ill_iss_op", bus.iss_op, ILLEGAL);

        // async reset while a dependent add waits on x5
        drive(1, 32'h00100293, 32'h114, 1, 0, 5'd0);
        cycle();
        drive(1, 32'h00028333, 32'h118, 1, 0, 5'd0);
        #1 check("x5_stall_ready", bus.instr_ready, 0);
        #1 reset = 1'b1;
        #1;
        check("arst_iss_valid", bus.iss_valid, 0);
        check("arst_ready", bus.instr_ready, 1);
        check("arst_stall", bus.stall_cnt, 0);
        #1 reset = 1'b0;
        model_reset();
        tick();
        #1;
        check("arst_accept_valid", bus.iss_valid, 1);
        check("arst_accept_rd", bus.iss_rd, 6);
        check("arst_accept_pc", bus.iss_pc, 32'h118);

        // long stall to saturate the counter
        drive(1, 32'h00100393, 32'h11C, 0, 0, 5'd0);
        cycle();
        repeat (65533) tick();
        #1 check("stall_near_sat", bus.stall_cnt, 16'hFFFE);
        repeat (7) tick();
        #1 check("stall_sat", bus.stall_cnt, 16'hFFFF);
        cycle();

        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;

        // random traffic
        pc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            v = bus.instr_valid;
            w = bus.instr;
            if (!bus.instr_valid || acc_last) begin
                v = ($urandom_range(0, 3) != 0);
                w = $urandom;
                w[11:7]  = 5'($urandom_range(0, 7));
                w[19:15] = 5'($urandom_range(0, 7));
                w[24:20] = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) w[6:0] = 7'($urandom);
                else w[6:0] = opcs[$urandom_range(0, 9)];
                pc = pc + 32'd4;
            end
            drive(v, w, pc, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
